rr_sel_sequencer: RTL and testbench
===================================

Name: rr_sel_sequencer

Overview:
- Round-robin arbiter that sits directly upstream of the 3-to-8 enable decoder.
- Samples an 8-bit request vector and issues a registered 3-bit channel index (sel) with a qualifying enable (en).
- The decoder converts sel/en into a one-hot grant.
- A grant is held until the owner signals done, withdraws its request, or a hold timeout expires.

Parameters:
- MAX_HOLD, default 16, maximum cycles one grant may stay asserted. Legal range 2..256. Hold counter width is clog2(MAX_HOLD).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- req, input, 8, per-channel request, level-sensitive, bit i = channel i.
- done, input, 1, release pulse from the current owner. Ignored while en=0.
- sel, output, 3, registered index of the granted channel.
- en, output, 1, registered grant-valid; feeds the decoder enable.
- timeout, output, 1, registered one-cycle pulse when a grant is revoked by hold expiry.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All outputs are registered.
- Reset (rst=1 at a rising edge), next cycle:
  - state=IDLE, sel=3'd0, en=0, timeout=0.
  - Round-robin pointer ptr=3'd7, so the first search starts at channel 0.
  - hold_cnt=0.
- rst overrides everything, including mid-grant: en drops on the very next edge.
- States: IDLE, GRANT, RELEASE. en=1 exactly when state=GRANT.
- Arbitration function, used in IDLE and RELEASE:
  - Winner = first set bit of req scanning ptr+1, ptr+2, … wrapping mod 8. ptr itself is checked last.
  - No set bit means no winner.
- IDLE:
  - Winner exists: sel<=winner, ptr<=winner, hold_cnt<=0, state<=GRANT.
  - No winner: stay in IDLE.
  - Latency: req sampled at edge N gives en=1 after edge N+1 (one cycle).
- GRANT (hold_cnt counts cycles 0..MAX_HOLD-1; sel stays stable for the whole grant). Evaluate in priority order:
  1. done=1 → state<=RELEASE, timeout<=0.
  2. Else req[sel]=0 (withdrawn) → RELEASE, timeout<=0.
  3. Else hold_cnt==MAX_HOLD-1 → RELEASE, timeout<=1.
  4. Else hold_cnt<=hold_cnt+1.
- GRANT timing consequences:
  - en stays high for exactly k+1 cycles when done is sampled at hold_cnt=k.
  - en stays high for exactly MAX_HOLD cycles on timeout.
  - done and expiry in the same cycle count as done: timeout stays 0.
- RELEASE:
  - en=0 for exactly one cycle.
  - sel holds the last granted value.
  - timeout is high only in this cycle when set, then cleared.
  - Arbitrate with the updated ptr: winner → GRANT; otherwise → IDLE.
  - Minimum gap between grants is 1 cycle.
- Re-grant: a channel that still requests after timeout may win again only if no other channel requests (fairness).
- done pulses while en=0 have no effect.
- req changes on non-granted bits during GRANT have no effect.

Test Plan:
1. Reset: rst=1 for 2 cycles with req=8'hFF → en=0, sel=0, timeout=0 during reset; one cycle after rst falls, en=1 with sel=0.
2. Basic handoff: req=8'b0010_0100 from reset, done pulsed at 3rd en cycle → sel=2 with en high for 3 cycles, then en=0 for 1 cycle, then sel=5, en=1.
3. Wrap-around: grant ch7 then release with req=8'h81 → next grant sel=0. Then with ptr=5 and req=8'b0000_0011 → grant order sel=0 then sel=1.
4. Timeout (MAX_HOLD=4): req=8'h08 held, done=0 → en high exactly 4 cycles; timeout=1 for the single en=0 cycle; then sel=3 re-granted.
5. Withdrawal and collision: granted ch4, req[4] drops → en=0 next cycle, timeout=0. Separately, done=1 at hold_cnt=MAX_HOLD-1 → release with timeout=0.
6. Mid-grant reset plus ignored done: rst=1 while en=1 with sel=6 → next cycle en=0, sel=0, and the first post-reset grant starts its search at ch0. A done pulse in IDLE changes nothing.

Source files
------------

// File: rtl/rr_sel_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_sel_sequencer_if
//  Description : Request/grant bundle between the requesters, the
//                round-robin sequencer and the downstream 3-to-8 decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_sel_sequencer_if;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic       en;
    logic       timeout;

    // Requester side: drives requests and release, observes the grant
    modport master (
        output req,
        output done,
        input  sel,
        input  en,
        input  timeout
    );

    // Sequencer side
    modport slave (
        input  req,
        input  done,
        output sel,
        output en,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/rr_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : rr_sel_sequencer
//  Description : Round-robin arbiter producing a registered channel index and
//                enable for a 3-to-8 decoder. A grant ends on done, request
//                withdrawal or hold expiry, followed by a one-cycle gap.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_sel_sequencer #(
    parameter int MAX_HOLD = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    rr_sel_sequencer_if.slave bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]        r_state;
    logic [2:0]        r_sel;
    logic [2:0]        r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_timeout;

    logic [1:0]        w_state_nxt;
    logic [2:0]        w_sel_nxt;
    logic [2:0]        w_ptr_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_timeout_nxt;

    logic              w_win_vld;
    logic [2:0]        w_win_idx;
    logic [2:0]        w_cand;

    // Round-robin search: ptr+1 first, wrapping, ptr itself checked last
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = 3'd0;
        w_cand    = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            w_cand = r_ptr + 3'(i);
            if (!w_win_vld && bus.req[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    // State and datapath registers; reset aims the first search at channel 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sel      <= 3'd0;
            r_ptr      <= 3'd7;
            r_hold_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_timeout  <= w_timeout_nxt;
        end
    end

    // Next-state logic: arbitrate when idle or releasing, track hold while granted
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_GRANT: begin
                if (bus.done) begin
                    w_state_nxt = S_RELEASE;
                end else if (!bus.req[r_sel]) begin
                    w_state_nxt = S_RELEASE;
                end else if (r_hold_cnt == C_HOLD_LAST) begin
                    w_state_nxt   = S_RELEASE;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            S_IDLE, S_RELEASE: begin
                if (w_win_vld) begin
                    w_state_nxt = S_GRANT;
                    w_sel_nxt   = w_win_idx;
                    w_ptr_nxt   = w_win_idx;
                    w_hold_nxt  = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; enable marks the grant state
    always_comb begin
        bus.sel     = r_sel;
        bus.en      = (r_state == S_GRANT);
        bus.timeout = r_timeout;
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_sel_sequencer
//  Description : Self-checking bench for rr_sel_sequencer (MAX_HOLD=4) with
//                directed scenarios and randomized traffic against a
//                behavioural grant model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_sel_sequencer;

    localparam int MH = 4;

    logic clk;
    logic rst;
    rr_sel_sequencer_if dif ();

    rr_sel_sequencer #(.MAX_HOLD(MH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who owns the bus, for how many cycles, and the
    // round-robin starting point
    bit         m_en;
    logic [2:0] m_sel;
    bit         m_to;
    int         m_ptr;
    int         m_held;

    logic       obs_en  [0:15];
    logic [2:0] obs_sel [0:15];
    logic       obs_to  [0:15];

    // Advance one clock and update the model with the inputs sampled on it
    task automatic tick();
        int w;
        @(posedge clk);
        if (rst) begin
            m_en = 0; m_sel = 3'd0; m_to = 0; m_ptr = 7; m_held = 0;
        end else if (m_en) begin
            m_held = m_held + 1;
            m_to   = 0;
            if (dif.done || !dif.req[m_sel] || m_held == MH) begin
                m_to = !dif.done && dif.req[m_sel];
                m_en = 0;
            end
        end else begin
            m_to = 0;
            w = -1;
            for (int k = 1; k <= 8; k++) begin
                if (w < 0 && dif.req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
            end
            if (w >= 0) begin
                m_en = 1; m_sel = 3'(w); m_ptr = w; m_held = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; dif.req = 8'h00; dif.done = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            rst = (c < 2); dif.req = 8'hFF; dif.done = 1'b0;
            tick();
            n_checks++;
            if (dif.en !== m_en || dif.sel !== m_sel || dif.timeout !== m_to) begin
                n_fail++;
                $display("FAIL reset c=%0d: en/sel/to got %b/%0d/%b expected %b/%0d/%b",
                         c, dif.en, dif.sel, dif.timeout, m_en, m_sel, m_to);
            end
            obs_en[c] = dif.en; obs_sel[c] = dif.sel; obs_to[c] = dif.timeout;
        end
        n_checks++;
        if (obs_en[1] !== 1'b0 || obs_sel[1] !== 3'd0 || obs_to[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: en/sel/to got %b/%0d/%b expected 0/0/0",
                     obs_en[1], obs_sel[1], obs_to[1]);
        end
        n_checks++;
        if (obs_en[2] !== 1'b1 || obs_sel[2] !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_first_grant: en/sel got %b/%0d expected 1/0", obs_en[2], obs_sel[2]);
        end
    endtask

    task automatic test_basic_handoff();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            dif.req = 8'b0010_0100; dif.done = (c == 3);
            tick();
            n_checks++;
            if (dif.en !== m_en || dif.sel !== m_sel || dif.timeout !== m_to) begin
                n_fail++;
                $display("FAIL handoff c=%0d: en/sel/to got %b/%0d/%b expected %b/%0d/%b",
                         c, dif.en, dif.sel, dif.timeout, m_en, m_sel, m_to);
            end
            obs_en[c] = dif.en; obs_sel[c] = dif.sel; obs_to[c] = dif.timeout;
        end
        n_checks++;
        if ({obs_en[0], obs_en[1], obs_en[2], obs_en[3], obs_en[4]} !== 5'b11101 ||
            obs_sel[2] !== 3'd2 || obs_sel[3] !== 3'd2 || obs_sel[4] !== 3'd5) begin
            n_fail++;
            $display("FAIL handoff_seq: en=%b%b%b%b%b sel2/3/4=%0d/%0d/%0d expected en=11101 sel=2/2/5",
                     obs_en[0], obs_en[1], obs_en[2], obs_en[3], obs_en[4],
                     obs_sel[2], obs_sel[3], obs_sel[4]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 3) do_reset();
            case (c)
                0:       begin dif.req = 8'h80; dif.done = 1'b0; end
                1:       begin dif.req = 8'h81; dif.done = 1'b1; end
                2:       begin dif.req = 8'h81; dif.done = 1'b0; end
                3:       begin dif.req = 8'h20; dif.done = 1'b0; end
                6:       begin dif.req = 8'h03; dif.done = 1'b1; end
                default: begin dif.req = 8'h03; dif.done = 1'b0; end
            endcase
            tick();
            n_checks++;
            if (dif.en !== m_en || dif.sel !== m_sel || dif.timeout !== m_to) begin
                n_fail++;
                $display("FAIL wrap c=%0d: en/sel/to got %b/%0d/%b expected %b/%0d/%b",
                         c, dif.en, dif.sel, dif.timeout, m_en, m_sel, m_to);
            end
            obs_en[c] = dif.en; obs_sel[c] = dif.sel; obs_to[c] = dif.timeout;
        end
        n_checks++;
        if (obs_sel[0] !== 3'd7 || obs_en[2] !== 1'b1 || obs_sel[2] !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_7_to_0: sel0=%0d en2=%b sel2=%0d expected 7/1/0",
                     obs_sel[0], obs_en[2], obs_sel[2]);
        end
        n_checks++;
        if (obs_en[5] !== 1'b1 || obs_sel[5] !== 3'd0 || obs_en[7] !== 1'b1 || obs_sel[7] !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap_order: en5/sel5=%b/%0d en7/sel7=%b/%0d expected 1/0 1/1",
                     obs_en[5], obs_sel[5], obs_en[7], obs_sel[7]);
        end
    endtask

    task automatic test_timeout();
        int n_en;
        do_reset();
        n_en = 0;
        for (int c = 0; c < 7; c++) begin
            dif.req = 8'h08; dif.done = 1'b0;
            tick();
            n_checks++;
            if (dif.en !== m_en || dif.sel !== m_sel || dif.timeout !== m_to) begin
                n_fail++;
                $display("FAIL timeout c=%0d: en/sel/to got %b/%0d/%b expected %b/%0d/%b",
                         c, dif.en, dif.sel, dif.timeout, m_en, m_sel, m_to);
            end
            obs_en[c] = dif.en; obs_sel[c] = dif.sel; obs_to[c] = dif.timeout;
            if (c < 5 && dif.en === 1'b1) n_en++;
        end
        n_checks++;
        if (n_en != MH || obs_en[4] !== 1'b0 || obs_to[4] !== 1'b1 || obs_to[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_len: en cycles=%0d en4=%b to3/to4=%b/%b expected %0d/0/0/1",
                     n_en, obs_en[4], obs_to[3], obs_to[4], MH);
        end
        n_checks++;
        if (obs_en[5] !== 1'b1 || obs_sel[5] !== 3'd3 || obs_to[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_regrant: en/sel/to got %b/%0d/%b expected 1/3/0",
                     obs_en[5], obs_sel[5], obs_to[5]);
        end
    endtask

    task automatic test_withdraw_collision();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            dif.req  = (c == 2 || c == 3) ? 8'h00 : 8'h10;
            dif.done = (c == 8);
            tick();
            n_checks++;
            if (dif.en !== m_en || dif.sel !== m_sel || dif.timeout !== m_to) begin
                n_fail++;
                $display("FAIL withdraw c=%0d: en/sel/to got %b/%0d/%b expected %b/%0d/%b",
                         c, dif.en, dif.sel, dif.timeout, m_en, m_sel, m_to);
            end
            obs_en[c] = dif.en; obs_sel[c] = dif.sel; obs_to[c] = dif.timeout;
        end
        n_checks++;
        if (obs_en[1] !== 1'b1 || obs_en[2] !== 1'b0 || obs_to[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL withdraw_release: en1/en2/to2 got %b/%b/%b expected 1/0/0",
                     obs_en[1], obs_en[2], obs_to[2]);
        end
        n_checks++;
        if (obs_en[7] !== 1'b1 || obs_en[8] !== 1'b0 || obs_to[8] !== 1'b0 || obs_sel[9] !== 3'd4) begin
            n_fail++;
            $display("FAIL done_at_expiry: en7/en8/to8/sel9 got %b/%b/%b/%0d expected 1/0/0/4",
                     obs_en[7], obs_en[8], obs_to[8], obs_sel[9]);
        end
    endtask

    task automatic test_midgrant_reset();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rst      = (c == 1);
            dif.req  = (c == 0 || c == 1) ? 8'h40 : (c == 2) ? 8'hFF : (c >= 6) ? 8'h04 : 8'h00;
            dif.done = (c == 5);
            tick();
            n_checks++;
            if (dif.en !== m_en || dif.sel !== m_sel || dif.timeout !== m_to) begin
                n_fail++;
                $display("FAIL midreset c=%0d: en/sel/to got %b/%0d/%b expected %b/%0d/%b",
                         c, dif.en, dif.sel, dif.timeout, m_en, m_sel, m_to);
            end
            obs_en[c] = dif.en; obs_sel[c] = dif.sel; obs_to[c] = dif.timeout;
        end
        rst = 1'b0;
        n_checks++;
        if (obs_sel[0] !== 3'd6 || obs_en[1] !== 1'b0 || obs_sel[1] !== 3'd0 ||
            obs_en[2] !== 1'b1 || obs_sel[2] !== 3'd0) begin
            n_fail++;
            $display("FAIL midreset_seq: sel0=%0d en1/sel1=%b/%0d en2/sel2=%b/%0d expected 6 0/0 1/0",
                     obs_sel[0], obs_en[1], obs_sel[1], obs_en[2], obs_sel[2]);
        end
        n_checks++;
        if (obs_en[5] !== 1'b0 || obs_en[6] !== 1'b1 || obs_sel[6] !== 3'd2 || obs_en[7] !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_done_ignored: en5/en6/sel6/en7 got %b/%b/%0d/%b expected 0/1/2/1",
                     obs_en[5], obs_en[6], obs_sel[6], obs_en[7]);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        r = 8'h00;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 9) < 3) r = 8'($urandom) & 8'($urandom);
            dif.req  = r;
            dif.done = ($urandom_range(0, 9) == 0);
            tick();
            n_checks++;
            if (dif.en !== m_en || dif.sel !== m_sel || dif.timeout !== m_to) begin
                n_fail++;
                $display("FAIL random c=%0d: en/sel/to got %b/%0d/%b expected %b/%0d/%b",
                         c, dif.en, dif.sel, dif.timeout, m_en, m_sel, m_to);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dif.req = 8'h00; dif.done = 1'b0;
        m_en = 0; m_sel = 3'd0; m_to = 0; m_ptr = 7; m_held = 0;
        @(negedge clk);
        test_reset();
        test_basic_handoff();
        test_wrap();
        test_timeout();
        test_withdraw_collision();
        test_midgrant_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
